// File: rtl/pmem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pmem_sequencer
// Description : Paged program memory loader/sequencer. It loads an image,
//               holds the core in reset, feeds instructions, and watches for
//               a halt loop or an exhausted cycle budget.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_sequencer #(
    parameter int PC_LEN    = 7,
    parameter int INSTR_LEN = 12,
    parameter int PAGES     = 4,
    parameter int RST_HOLD  = 4,
    localparam int PG_W     = $clog2(PAGES)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 LD_VALID,
    input  logic [INSTR_LEN-1:0] LD_DATA,
    input  logic                 LD_LAST,
    output logic                 LD_READY,
    input  logic [PC_LEN-1:0]    PC,
    input  logic                 PAGE_WE,
    input  logic [PG_W-1:0]      PAGE_IN,
    input  logic [15:0]          MAX_CYCLES,
    output logic [INSTR_LEN-1:0] INSTR,
    output logic                 CORE_RSTN,
    output logic                 HALTED,
    output logic                 TIMEOUT
);

    localparam int c_ADDR_W            = PG_W + PC_LEN;
    localparam int c_DEPTH             = PAGES << PC_LEN;
    localparam int c_HOLD_W            = $clog2(RST_HOLD + 1);
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(c_DEPTH - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [INSTR_LEN-1:0]   r_mem [c_DEPTH];
    logic [c_ADDR_W-1:0]    r_ld_addr;
    logic [PG_W-1:0]        r_page;
    logic [c_HOLD_W-1:0]    r_hold;
    logic [15:0]            r_cyc;
    logic [PC_LEN-1:0]      r_pc_prev;
    logic                   r_first;
    logic                   r_halted;
    logic                   r_timeout;
    logic [INSTR_LEN-1:0]   r_instr;

    logic                   w_ld_ready;
    logic                   w_accept;
    logic [15:0]            w_cyc_inc;
    logic                   w_halt_hit;
    logic                   w_tmo_hit;

    // Ready is masked by RST so nothing is accepted while reset is held.
    assign w_ld_ready = (r_state == S_LOAD) && !RST;
    assign w_accept   = LD_VALID && w_ld_ready;
    assign w_cyc_inc  = r_cyc + 16'd1;
    assign w_halt_hit = (r_state == S_RUN) && !r_first && !PAGE_WE && (PC == r_pc_prev);
    assign w_tmo_hit  = (r_state == S_RUN) && (MAX_CYCLES != 16'd0) && (w_cyc_inc == MAX_CYCLES);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: if (w_accept && (LD_LAST || (r_ld_addr == c_LAST_ADDR))) w_state_nxt = S_HOLD;
            S_HOLD: if (r_hold == c_HOLD_LAST) w_state_nxt = S_RUN;
            S_RUN:  if (w_halt_hit || w_tmo_hit) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_DONE;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_LOAD;
            r_ld_addr <= '0;
            r_page    <= '0;
            r_hold    <= '0;
            r_cyc     <= '0;
            r_pc_prev <= '0;
            r_first   <= 1'b1;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_instr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_ld_addr <= r_ld_addr + 1'b1;
            r_hold <= (r_state == S_HOLD) ? r_hold + 1'b1 : '0;
            if (r_state == S_RUN) begin
                r_cyc     <= w_cyc_inc;
                r_pc_prev <= PC;
                r_first   <= 1'b0;
                if (PAGE_WE)    r_page    <= PAGE_IN;
                if (w_halt_hit) r_halted  <= 1'b1;
                if (w_tmo_hit)  r_timeout <= 1'b1;
            end
            // Fetch uses the page as it stood before this edge's page write.
            r_instr <= ((r_state == S_RUN) && (w_state_nxt == S_RUN)) ? r_mem[{r_page, PC}] : '0;
        end
    end

    // Storage survives RST so a partial reload leaves older words intact.
    always_ff @(posedge CLK) begin
        if (w_accept) r_mem[r_ld_addr] <= LD_DATA;
    end

    assign LD_READY  = w_ld_ready;
    assign CORE_RSTN = (r_state == S_RUN);
    assign INSTR     = r_instr;
    assign HALTED    = r_halted;
    assign TIMEOUT   = r_timeout;

endmodule
`default_nettype wire
